// File: rtl/rv_fetch_ctrl.sv
// rv_fetch_ctrl: instruction fetch controller.
// Owns the fetch PC, issues word reads to a synchronous-read instruction
// memory (one-cycle latency), and buffers returned words in a 2-entry skid
// FIFO so that a stalled decode stage never loses a fetched instruction.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   BOOT  | just out of reset, no reads yet; moves to RUN on the next edge
//   RUN   | issuing sequential reads while FIFO space allows
//   HALT  | fetch PC was bad; no reads, FIFO still drains, fault flagged
module rv_fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_ren_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              redirect_i,
    input  logic [63:0]       redirect_pc_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [63:0]       instr_pc_o,
    output logic              fetch_fault_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [63:0] tag_q, tag_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] data_q [2];
    logic [31:0] data_d [2];
    logic [63:0] pcs_q [2];
    logic [63:0] pcs_d [2];

    logic pc_legal;
    logic redir_legal;
    logic pop;
    logic push;
    logic room;
    logic issue;

    // A PC is fetchable when word aligned and inside the memory window.
    function automatic logic is_legal(input logic [63:0] pc);
        return (pc[1:0] == 2'b00) && (pc[63:ADDR_W+2] == '0);
    endfunction

    // Issue decision, FIFO bookkeeping and next-state logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tag_d      = tag_q;
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        data_d     = data_q;
        pcs_d      = pcs_q;

        pc_legal    = is_legal(pc_q);
        redir_legal = is_legal(redirect_pc_i);

        instr_valid_o = (cnt_q != 2'd0) & ~redirect_i;
        pop           = instr_valid_o & instr_ready_i;
        push          = inflight_q & ~redirect_i;
        // The outstanding read plus buffered words must still fit after this
        // cycle's pop, so a push can never overflow the two entries.
        room  = ({1'b0, cnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
        issue = (state_q == ST_RUN) & ~redirect_i & pc_legal & room;

        inflight_d = issue;
        if (issue) begin
            tag_d = pc_q;
            pc_d  = pc_q + 64'd4;
        end

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (!pc_legal) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase

        if (redirect_i) begin
            pc_d     = redirect_pc_i;
            state_d  = redir_legal ? ST_RUN : ST_HALT;
            cnt_d    = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = mem_rdata_i;
                pcs_d[wr_ptr_q]  = tag_q;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Registered fetch state and FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            tag_q      <= 64'h0;
            cnt_q      <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            data_q[0]  <= 32'h0;
            data_q[1]  <= 32'h0;
            pcs_q[0]   <= 64'h0;
            pcs_q[1]   <= 64'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            data_q     <= data_d;
            pcs_q      <= pcs_d;
        end
    end

    // Memory port and decode-side outputs.
    always_comb begin
        mem_ren_o     = issue;
        mem_addr_o    = pc_q[ADDR_W+1:2];
        instr_o       = data_q[rd_ptr_q];
        instr_pc_o    = pcs_q[rd_ptr_q];
        fetch_fault_o = (state_q == ST_HALT);
    end

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Testbench for rv_fetch_ctrl: memory model, in-order scoreboard of expected
// instruction PCs, a table of redirect vectors and a few hand sequences.
module tb_rv_fetch_ctrl;

    localparam int ADDR_W = 8;
    localparam logic [63:0] MEM_TOP = 64'h3FC;

    logic              clk;
    logic              rst_n;
    logic              mem_ren_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_rdata_i;
    logic              redirect_i;
    logic [63:0]       redirect_pc_i;
    logic              instr_valid_o;
    logic              instr_ready_i;
    logic [31:0]       instr_o;
    logic [63:0]       instr_pc_o;
    logic              fetch_fault_o;

    rv_fetch_ctrl #(.RESET_PC(64'h0), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_ren_o     (mem_ren_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rdata_i   (mem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .fetch_fault_o (fetch_fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [63:0] exp_q [$];
    logic [31:0] mem [256];

    function automatic logic [31:0] word_of(input logic [63:0] pc);
        return {8'hC3, pc[9:2], ~pc[9:2], pc[9:2] ^ 8'h5A};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = word_of(64'(i) << 2);
        mem_rdata_i = 32'h0;
    end

    // Synchronous-read instruction memory, one-cycle latency.
    always @(posedge clk) begin
        if (mem_ren_o) mem_rdata_i <= mem[mem_addr_o];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_seq(input logic [63:0] start);
        exp_q.delete();
        for (logic [63:0] p = start; p <= MEM_TOP; p += 64'd4) exp_q.push_back(p);
    endtask

    // Every accepted instruction must be the next expected PC with its word.
    always @(negedge clk) begin
        if (rst_n && instr_valid_o && instr_ready_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL extra_instr: got pc %0h expected none at %0t", instr_pc_o, $time);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("stream_pc", instr_pc_o, e);
                chk("stream_instr", {32'h0, instr_o}, {32'h0, word_of(e)});
            end
        end
    end

    typedef struct {
        logic [63:0] pc;
        logic        exp_fault;
    } vec_t;

    vec_t tbl [8];

    task automatic do_redirect(input logic [63:0] pc, input logic exp_fault);
        @(posedge clk); #1;
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        instr_ready_i = 1'b1;
        if (exp_fault) exp_q.delete();
        else push_seq(pc);
        @(negedge clk);
        chk("redir_R_valid", {63'h0, instr_valid_o}, 64'h0);
        chk("redir_R_ren", {63'h0, mem_ren_o}, 64'h0);
        @(posedge clk); #1;
        redirect_i = 1'b0;
        @(negedge clk);
        chk("redir_R1_fault", {63'h0, fetch_fault_o}, {63'h0, exp_fault});
        chk("redir_R1_ren", {63'h0, mem_ren_o}, {63'h0, ~exp_fault});
        chk("redir_R1_valid", {63'h0, instr_valid_o}, 64'h0);
        if (!exp_fault) chk("redir_R1_addr", {56'h0, mem_addr_o}, {56'h0, pc[9:2]});
        @(negedge clk);
        chk("redir_R2_valid", {63'h0, instr_valid_o}, 64'h0);
        @(negedge clk);
        chk("redir_R3_valid", {63'h0, instr_valid_o}, {63'h0, ~exp_fault});
        if (!exp_fault) chk("redir_R3_pc", instr_pc_o, pc);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        tbl[0] = '{64'h40, 1'b0};
        tbl[1] = '{64'h42, 1'b1};
        tbl[2] = '{64'h10, 1'b0};
        tbl[3] = '{64'h400, 1'b1};
        tbl[4] = '{64'h200, 1'b0};
        tbl[5] = '{64'h1, 1'b1};
        tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b1};
        tbl[7] = '{64'h0, 1'b0};

        rst_n         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 64'h0;
        instr_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ren", {63'h0, mem_ren_o}, 64'h0);
        chk("rst_addr", {56'h0, mem_addr_o}, 64'h0);
        chk("rst_valid", {63'h0, instr_valid_o}, 64'h0);
        chk("rst_instr", {32'h0, instr_o}, 64'h0);
        chk("rst_pc", instr_pc_o, 64'h0);
        chk("rst_fault", {63'h0, fetch_fault_o}, 64'h0);

        // Reset release and first-fetch latency.
        push_seq(64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("boot_ren", {63'h0, mem_ren_o}, 64'h0);
        @(negedge clk);
        chk("first_ren", {63'h0, mem_ren_o}, 64'h1);
        chk("first_addr", {56'h0, mem_addr_o}, 64'h0);
        @(negedge clk);
        chk("second_addr", {56'h0, mem_addr_o}, 64'h1);
        chk("second_valid", {63'h0, instr_valid_o}, 64'h0);
        @(negedge clk);
        chk("first_valid", {63'h0, instr_valid_o}, 64'h1);
        chk("first_pc", instr_pc_o, 64'h0);

        // Back-to-back throughput.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("thru_valid", {63'h0, instr_valid_o}, 64'h1);
            chk("thru_ren", {63'h0, mem_ren_o}, 64'h1);
        end

        // Five-cycle stall: issue stops, head held.
        @(posedge clk); #1;
        instr_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk("stall_ren", {63'h0, mem_ren_o}, 64'h0);
            chk("stall_valid", {63'h0, instr_valid_o}, 64'h1);
            chk("stall_pc", instr_pc_o, exp_q[0]);
            chk("stall_instr", {32'h0, instr_o}, {32'h0, word_of(exp_q[0])});
        end
        @(posedge clk); #1;
        instr_ready_i = 1'b1;
        @(negedge clk);
        chk("resume_ren", {63'h0, mem_ren_o}, 64'h1);

        // Fill the FIFO so the first redirect flushes two entries.
        @(posedge clk); #1;
        instr_ready_i = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) do_redirect(tbl[i].pc, tbl[i].exp_fault);

        // Sequential fetch running into the top of memory.
        do_redirect(64'h3F0, 1'b0);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fetch_fault_o) begin
                got = 1'b1;
                break;
            end
        end
        chk("eom_fault", {63'h0, got}, 64'h1);
        chk("eom_ren", {63'h0, mem_ren_o}, 64'h0);
        repeat (4) @(negedge clk);
        chk("eom_drained", 64'(exp_q.size()), 64'h0);
        chk("eom_valid", {63'h0, instr_valid_o}, 64'h0);
        chk("eom_fault_hold", {63'h0, fetch_fault_o}, 64'h1);

        // Asynchronous reset with the FIFO full.
        do_redirect(64'h100, 1'b0);
        @(posedge clk); #1;
        instr_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_ren", {63'h0, mem_ren_o}, 64'h0);
        chk("arst_addr", {56'h0, mem_addr_o}, 64'h0);
        chk("arst_valid", {63'h0, instr_valid_o}, 64'h0);
        chk("arst_instr", {32'h0, instr_o}, 64'h0);
        chk("arst_pc", instr_pc_o, 64'h0);
        chk("arst_fault", {63'h0, fetch_fault_o}, 64'h0);
        @(posedge clk); #1;
        push_seq(64'h0);
        instr_ready_i = 1'b1;
        rst_n = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (instr_valid_o) begin
                got = 1'b1;
                break;
            end
        end
        chk("restart_seen", {63'h0, got}, 64'h1);
        chk("restart_pc", instr_pc_o, 64'h0);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
